// File: rtl/uart_pkg.sv
// Shared UART definitions: feeder FSM states, word geometry and the default baud divider.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_BUSY = 2'd1,
      WAIT_DONE = 2'd2
   } feeder_state_e;

   localparam int WORD_BYTES = 4;

   // 100 MHz clock at 115200 baud, shared with the transmitter.
   localparam int CLK_PER_HALF_BIT = 434;

   function automatic logic [7:0] word_byte(logic [31:0] w, int k, bit lsb_first);
      int sel;
      sel = lsb_first ? k : (WORD_BYTES - 1 - k);
      return w[8*sel +: 8];
   endfunction

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Core-write and transmitter-issue signals of the UART TX feeder.
interface uart_tx_feeder_if #(
   parameter int DEPTH_LOG2 = 4
);
   logic                  wr_en;
   logic                  wr_word;
   logic [31:0]           wr_data;
   logic                  wr_ready;
   logic                  overflow;
   logic [7:0]            sdata;
   logic                  tx_start;
   logic                  tx_busy;
   logic [DEPTH_LOG2:0]   count;
   logic                  empty;

   modport master (
      output wr_en, wr_word, wr_data, tx_busy,
      input  wr_ready, overflow, sdata, tx_start, count, empty
   );

   modport slave (
      input  wr_en, wr_word, wr_data, tx_busy,
      output wr_ready, overflow, sdata, tx_start, count, empty
   );
endinterface

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with 1- or 4-byte push and single-byte pop; occupancy tracked explicitly.
module uart_byte_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH_LOG2 = 4,
   parameter bit LSB_FIRST  = 1'b1
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  push,
   input  logic                  push_word,
   input  logic [31:0]           push_data,
   input  logic                  pop,
   output logic [7:0]            rd_data,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  ready,
   output logic                  empty
);
   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [7:0]            mem_q [DEPTH];
   logic [7:0]            mem_d [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2-1:0] wr_idx;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic [DEPTH_LOG2:0]   push_n;
   logic [DEPTH_LOG2:0]   free;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      wr_idx   = wr_ptr_q;
      push_n   = '0;
      if (push) begin
         if (push_word) begin
            for (int k = 0; k < WORD_BYTES; k++) begin
               wr_idx        = wr_ptr_q + DEPTH_LOG2'(k);
               mem_d[wr_idx] = word_byte(push_data, k, LSB_FIRST);
            end
            push_n = (DEPTH_LOG2+1)'(WORD_BYTES);
         end else begin
            mem_d[wr_ptr_q] = push_data[7:0];
            push_n          = (DEPTH_LOG2+1)'(1);
         end
         wr_ptr_d = wr_ptr_q + push_n[DEPTH_LOG2-1:0];
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      end
      count_d = count_q + push_n - (DEPTH_LOG2+1)'(pop);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries data only, so it is left out of reset.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // Word-sized headroom is demanded for byte writes too, so the core sees one rule.
   assign free    = (DEPTH_LOG2+1)'(DEPTH) - count_q;
   assign ready   = (free >= (DEPTH_LOG2+1)'(WORD_BYTES));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rd_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers core writes and issues them one byte at a time, paced by the transmitter's busy flag.
module uart_tx_feeder
   import uart_pkg::*;
#(
   parameter int DEPTH_LOG2 = 4,
   parameter bit LSB_FIRST  = 1'b1
) (
   input  logic             clk,
   input  logic             rstn,
   uart_tx_feeder_if.slave  bus
);
   feeder_state_e state_q, state_d;
   logic [7:0]    sdata_q, sdata_d;
   logic          tx_start_q, tx_start_d;
   logic          overflow_q, overflow_d;
   logic          push, pop;
   logic [7:0]    fifo_rd_data;
   logic          fifo_ready, fifo_empty;
   logic [DEPTH_LOG2:0] fifo_count;

   assign push = bus.wr_en && fifo_ready;

   uart_byte_fifo #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .LSB_FIRST  (LSB_FIRST)
   ) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .push      (push),
      .push_word (bus.wr_word),
      .push_data (bus.wr_data),
      .pop       (pop),
      .rd_data   (fifo_rd_data),
      .count     (fifo_count),
      .ready     (fifo_ready),
      .empty     (fifo_empty)
   );

   always_comb begin
      state_d    = state_q;
      sdata_d    = sdata_q;
      tx_start_d = 1'b0;
      pop        = 1'b0;
      overflow_d = overflow_q | (bus.wr_en & ~fifo_ready);
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty && !bus.tx_busy) begin
               pop        = 1'b1;
               sdata_d    = fifo_rd_data;
               tx_start_d = 1'b1;
               state_d    = WAIT_BUSY;
            end
         end
         WAIT_BUSY: begin
            if (bus.tx_busy) state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (!bus.tx_busy) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         sdata_q    <= 8'h00;
         tx_start_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sdata_q    <= sdata_d;
         tx_start_q <= tx_start_d;
         overflow_q <= overflow_d;
      end
   end

   assign bus.wr_ready = fifo_ready;
   assign bus.overflow = overflow_q;
   assign bus.sdata    = sdata_q;
   assign bus.tx_start = tx_start_q;
   assign bus.count    = fifo_count;
   assign bus.empty    = fifo_empty;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: LSB-first and MSB-first instances share stimulus and a busy model.
module tb_uart_tx_feeder;
   localparam int DL2      = 4;
   localparam int BUSY_LEN = 5;
   localparam int GAP      = BUSY_LEN + 3;

   logic        clk = 1'b0;
   logic        rstn;
   logic        wr_en, wr_word, hold_busy;
   logic [31:0] wr_data;
   int          cyc = 0;
   int          bcnt_l, bcnt_m;
   int          n_checks = 0;
   int          n_pass = 0;

   logic [7:0]  issued_l[$];
   logic [7:0]  issued_m[$];
   int          cyc_l[$];

   always #5 clk = ~clk;

   uart_tx_feeder_if #(.DEPTH_LOG2(DL2)) if_l ();
   uart_tx_feeder_if #(.DEPTH_LOG2(DL2)) if_m ();

   uart_tx_feeder #(.DEPTH_LOG2(DL2), .LSB_FIRST(1'b1)) dut_l (.clk(clk), .rstn(rstn), .bus(if_l));
   uart_tx_feeder #(.DEPTH_LOG2(DL2), .LSB_FIRST(1'b0)) dut_m (.clk(clk), .rstn(rstn), .bus(if_m));

   assign if_l.wr_en   = wr_en;
   assign if_l.wr_word = wr_word;
   assign if_l.wr_data = wr_data;
   assign if_m.wr_en   = wr_en;
   assign if_m.wr_word = wr_word;
   assign if_m.wr_data = wr_data;
   assign if_l.tx_busy = hold_busy | (bcnt_l > 0);
   assign if_m.tx_busy = hold_busy | (bcnt_m > 0);

   // Transmitter model: busy rises the cycle after tx_start and lasts BUSY_LEN cycles.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bcnt_l <= 0;
         bcnt_m <= 0;
      end else begin
         if (if_l.tx_start) bcnt_l <= BUSY_LEN;
         else if (bcnt_l > 0) bcnt_l <= bcnt_l - 1;
         if (if_m.tx_start) bcnt_m <= BUSY_LEN;
         else if (bcnt_m > 0) bcnt_m <= bcnt_m - 1;
      end
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rstn && if_l.tx_start) begin
         issued_l.push_back(if_l.sdata);
         cyc_l.push_back(cyc);
      end
      if (rstn && if_m.tx_start) issued_m.push_back(if_m.sdata);
   end

   typedef struct {
      bit          word;
      logic [31:0] data;
      int          n;
      logic [31:0] exp_l;
      logic [31:0] exp_m;
   } vec_t;

   vec_t vecs[4];

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(bit w, logic [31:0] d);
      wr_en   = 1'b1;
      wr_word = w;
      wr_data = d;
      tick();
      wr_en   = 1'b0;
      wr_word = 1'b0;
      wr_data = 32'h0;
   endtask

   task automatic clear_logs();
      issued_l.delete();
      issued_m.delete();
      cyc_l.delete();
   endtask

   function automatic logic [31:0] q_at(input logic [7:0] q[$], int k);
      return (k < q.size()) ? {24'h0, q[k]} : 32'hDEAD;
   endfunction

   initial begin
      logic [31:0] e;
      rstn = 1'b0; wr_en = 1'b0; wr_word = 1'b0; wr_data = '0; hold_busy = 1'b0;
      vecs[0] = '{1'b0, 32'h00000041, 1, 32'h00000041, 32'h00000041};
      vecs[1] = '{1'b1, 32'h44434241, 4, 32'h44434241, 32'h41424344};
      vecs[2] = '{1'b0, 32'h123456A5, 1, 32'h000000A5, 32'h000000A5};
      vecs[3] = '{1'b1, 32'h00FF807F, 4, 32'h00FF807F, 32'h7F80FF00};
      #12 rstn = 1'b1;
      tick();

      check("rst_count",    32'(if_l.count),    32'd0);
      check("rst_empty",    32'(if_l.empty),    32'd1);
      check("rst_wr_ready", 32'(if_l.wr_ready), 32'd1);
      check("rst_overflow", 32'(if_l.overflow), 32'd0);
      check("rst_tx_start", 32'(if_l.tx_start), 32'd0);
      check("rst_sdata",    32'(if_l.sdata),    32'h00);

      // Single byte: tx_start two cycles after the write cycle.
      do_write(1'b0, 32'h00000041);
      check("lat_count1",   32'(if_l.count),    32'd1);
      check("lat_start_c1", 32'(if_l.tx_start), 32'd0);
      tick();
      check("lat_start_c2", 32'(if_l.tx_start), 32'd1);
      check("lat_sdata",    32'(if_l.sdata),    32'h41);
      check("lat_count0",   32'(if_l.count),    32'd0);
      tick();
      check("lat_pulse_end", 32'(if_l.tx_start), 32'd0);
      repeat (20) tick();
      check("lat_one_issue", 32'(issued_l.size()), 32'd1);

      // Table of writes, each drained before the next.
      for (int v = 0; v < 4; v++) begin
         clear_logs();
         do_write(vecs[v].word, vecs[v].data);
         repeat (45) tick();
         check($sformatf("vec%0d_n_lsb", v), 32'(issued_l.size()), 32'(vecs[v].n));
         check($sformatf("vec%0d_n_msb", v), 32'(issued_m.size()), 32'(vecs[v].n));
         for (int k = 0; k < vecs[v].n; k++) begin
            e = vecs[v].exp_l;
            check($sformatf("vec%0d_lsb_b%0d", v, k), q_at(issued_l, k), {24'h0, e[8*k +: 8]});
            e = vecs[v].exp_m;
            check($sformatf("vec%0d_msb_b%0d", v, k), q_at(issued_m, k), {24'h0, e[8*k +: 8]});
            if (k > 0 && k < cyc_l.size())
               check($sformatf("vec%0d_gap%0d", v, k), 32'(cyc_l[k] - cyc_l[k-1]), 32'(GAP));
         end
         check($sformatf("vec%0d_empty", v), 32'(if_l.empty), 32'd1);
      end

      // Word push in the same cycle the FSM pops the only buffered byte.
      clear_logs();
      do_write(1'b0, 32'h00000055);
      do_write(1'b1, 32'h99887766);
      check("sim_count",    32'(if_l.count),    32'd4);
      check("sim_tx_start", 32'(if_l.tx_start), 32'd1);
      check("sim_sdata",    32'(if_l.sdata),    32'h55);
      repeat (50) tick();
      check("sim_n", 32'(issued_l.size()), 32'd5);
      for (int k = 0; k < 5; k++) begin
         e = (k == 0) ? 32'h55 : 32'h66 + 32'(k - 1) * 32'h11;
         check($sformatf("sim_b%0d", k), q_at(issued_l, k), e);
      end

      // Fill while the transmitter stays busy.
      clear_logs();
      hold_busy = 1'b1;
      tick();
      do_write(1'b1, 32'h03020100);
      check("fill_c4", 32'(if_l.count), 32'd4);
      do_write(1'b1, 32'h07060504);
      check("fill_c8", 32'(if_l.count), 32'd8);
      do_write(1'b1, 32'h0B0A0908);
      check("fill_c12",  32'(if_l.count),    32'd12);
      check("fill_rdy12", 32'(if_l.wr_ready), 32'd1);
      do_write(1'b0, 32'h0000000C);
      check("fill_c13",   32'(if_l.count),    32'd13);
      check("fill_rdy13", 32'(if_l.wr_ready), 32'd0);
      check("fill_ovf0",  32'(if_l.overflow), 32'd0);
      do_write(1'b1, 32'hEEEEEEEE);
      check("fill_ovf1",     32'(if_l.overflow), 32'd1);
      check("fill_c_hold",   32'(if_l.count),    32'd13);
      check("fill_no_issue", 32'(issued_l.size()), 32'd0);
      hold_busy = 1'b0;
      repeat (13 * GAP + 10) tick();
      check("fill_n", 32'(issued_l.size()), 32'd13);
      for (int k = 0; k < 13; k++)
         check($sformatf("fill_b%0d", k), q_at(issued_l, k), 32'(k));
      check("fill_ovf_sticky", 32'(if_l.overflow), 32'd1);

      // Word write straddling the top of the buffer (indices 13..15, 0).
      clear_logs();
      do_write(1'b1, 32'hA3A2A1A0);
      repeat (45) tick();
      check("wrap_n", 32'(issued_l.size()), 32'd4);
      for (int k = 0; k < 4; k++)
         check($sformatf("wrap_b%0d", k), q_at(issued_l, k), 32'hA0 + 32'(k));

      // Asynchronous reset while a byte is being issued.
      do_write(1'b1, 32'hC3C2C1C0);
      tick();
      check("arst_pre_start", 32'(if_l.tx_start), 32'd1);
      #3 rstn = 1'b0;
      #1;
      check("arst_tx_start", 32'(if_l.tx_start), 32'd0);
      check("arst_count",    32'(if_l.count),    32'd0);
      check("arst_overflow", 32'(if_l.overflow), 32'd0);
      check("arst_empty",    32'(if_l.empty),    32'd1);
      check("arst_sdata",    32'(if_l.sdata),    32'h00);
      #2 rstn = 1'b1;
      tick();
      clear_logs();
      repeat (40) tick();
      check("arst_no_issue", 32'(issued_l.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
